alu_writeback_stage: RTL
========================

// Module: alu_writeback_stage
// PURPOSE
//  Downstream stage of ALU_with_extra_OP: registers ALU Result/MulResult/Zero/CarryOut on a valid/ready
//  handshake, sequences register-file writes (one write for normal ops, two for MUL: LO then HI), and
//  maintains the architectural Z/C flag register read by branch logic. Sits between ALU and register file.
// PARAMETERS
//  DATA_W   16  datapath width; MulResult is 2*DATA_W
//  REG_AW   3   register-file address width (8 registers)
//  OP_W     3   ALUOp width
// PORTS
//  Clock      in   1        single clock, rising edge
//  Reset      in   1        synchronous, active-high
//  InValid    in   1        ALU output valid this cycle
//  InReady    out  1        stage can accept; transfer when InValid & InReady
//  ALUOp      in   OP_W     op that produced the result (000 AND,001 OR,010 ADD,110 SUB,011 XOR,100 SLLI,101 ROR,111 MUL)
//  RegWrite   in   1        instruction writes a destination register
//  Rd         in   REG_AW   destination register
//  Result     in   DATA_W   ALU result
//  MulResult  in   2*DATA_W product (used only when ALUOp==111)
//  Zero       in   1        ALU zero flag
//  CarryOut   in   1        ALU carry/borrow
//  RfWe       out  1        register-file write enable
//  RfAddr     out  REG_AW   write address
//  RfData     out  DATA_W   write data
//  FlagZ      out  1        architectural zero flag
//  FlagC      out  1        architectural carry flag
//  Busy       out  1        a write is pending (state != S_IDLE)
// BEHAVIOUR
//  - Reset: state S_IDLE; RfWe/RfAddr/RfData/FlagZ/FlagC/Busy = 0; InReady = 1; pending data discarded.
//  - FSM: S_IDLE -> S_WR on accept with RegWrite=1; S_WR -> S_HI if captured op is MUL, else -> S_WR on
//    new accept with RegWrite=1, else S_IDLE; S_HI -> S_WR on accept with RegWrite=1, else S_IDLE.
//  - Latency: write appears exactly 1 cycle after accept. RfWe/RfAddr/RfData are registered outputs.
//  - Non-MUL: single write RfAddr=Rd, RfData=Result. Throughput 1/cycle (InReady high in S_IDLE, S_WR).
//  - MUL: cycle 1 RfAddr=Rd, RfData=MulResult[15:0]; cycle 2 RfAddr=Rd+1 mod 2^REG_AW (111 wraps to 000),
//    RfData=MulResult[31:16]. InReady=0 during the LO cycle; next op accepted in HI cycle, written after.
//  - RegWrite=0: accepted, no write scheduled, flags still update.
//  - Flags update on accept only: FlagZ <= Zero (MUL: MulResult==0); FlagC <= CarryOut for ADD/SUB only,
//    held for all other ops (MUL included). Flags visible the cycle after accept.
//  - InValid while InReady=0: no capture; upstream holds inputs (no drop, no duplication).
//  - Reset asserted mid-MUL: HI write cancelled, Reset wins over any simultaneous accept.
// CONFIGURATION
//  ALU_WB_MUL_EN defined: MUL two-write sequence, S_HI present, MulResult used.
//  ALU_WB_MUL_EN undefined: ALUOp 111 treated as a plain single write of Result; MulResult ignored;
//    S_HI removed; InReady tied 1 outside Reset.
// STRUCTURE
//  Package cpu16_pkg: ALUOp localparams (OP_AND..OP_MUL), FSM state encoding, DATA_W/REG_AW defaults.
//  Sub-module alu_flag_reg: Z/C register with per-flag update enables; FSM + write mux stay top-level.
// TESTING
//  1 ADD A=10,B=20: Result=30,RegWrite=1,Rd=2 -> next cycle RfWe=1,RfAddr=2,RfData=30,FlagZ=0,FlagC=0.
//  2 SUB Result=0,Zero=1 then XOR Result=5,CarryOut=1 back-to-back -> two writes consecutive cycles;
//    FlagZ 1 then 0; FlagC holds SUB value (CarryOut ignored for XOR).
//  3 MUL MulResult=32'h0001_0002,Rd=7 -> RfWe 2 cycles: (7,16'h0002) then (0,16'h0001); InReady=0 LO cycle;
//    FlagC held; FlagZ=0.
//  4 MUL then ADD held valid through stall -> ADD accepted in HI cycle, written cycle after; no loss/dup.
//  5 Reset pulsed during MUL LO cycle -> no HI write; all outputs 0 next cycle; InReady=1.
//  6 Build without ALU_WB_MUL_EN, ALUOp=111,Result=16'h00FF,Rd=3 -> single write (3,16'h00FF); InReady stays 1.

Source files
------------

// File: rtl/cpu16_pkg.sv
// cpu16_pkg
//   Shared definitions for the 16-bit CPU slice around the ALU writeback stage.
//   It holds the default datapath widths, the ALUOp codes (OP_AND..OP_MUL),
//   the writeback FSM state encoding, and a helper that classifies the ops
//   that produce a meaningful carry/borrow.
package cpu16_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_REG_AW = 3;
  localparam int CPU_OP_W   = 3;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SLLI = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  // S_WR: a register-file write is on the outputs this cycle.
  // S_HI: the high half of a product is on the outputs this cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WR   = 2'b01,
    S_HI   = 2'b10
  } wb_state_e;

  // Only ADD and SUB produce a carry/borrow that the flag register keeps.
  function automatic logic op_sets_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_writeback_stage_if.sv
// alu_writeback_stage_if
//   Valid/ready link from the ALU to the writeback stage.
//   master : the ALU side. It drives InValid, ALUOp, RegWrite, Rd, Result,
//            MulResult, Zero and CarryOut, and it reads InReady.
//   slave  : the writeback stage. It reads the ALU signals and drives InReady.
//   A transfer happens on a rising clock edge when InValid & InReady.
interface alu_writeback_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int OP_W   = 3
);
  logic                  InValid;
  logic                  InReady;
  logic [OP_W-1:0]       ALUOp;
  logic                  RegWrite;
  logic [REG_AW-1:0]     Rd;
  logic [DATA_W-1:0]     Result;
  logic [2*DATA_W-1:0]   MulResult;
  logic                  Zero;
  logic                  CarryOut;

  modport master (
    output InValid, ALUOp, RegWrite, Rd, Result, MulResult, Zero, CarryOut,
    input  InReady
  );

  modport slave (
    input  InValid, ALUOp, RegWrite, Rd, Result, MulResult, Zero, CarryOut,
    output InReady
  );
endinterface

// File: rtl/alu_flag_reg.sv
// alu_flag_reg
//   Holds the architectural Z/C flags read by branch logic. Each flag has its
//   own load enable, and each flag keeps its value when its enable is low.
//   Ports: clk, rst (synchronous, active-high), z_en/z_in, c_en/c_in,
//          flag_z, flag_c (registered).
module alu_flag_reg (
  input  logic clk,
  input  logic rst,
  input  logic z_en,
  input  logic z_in,
  input  logic c_en,
  input  logic c_in,
  output logic flag_z,
  output logic flag_c
);

  logic flag_z_r;
  logic flag_c_r;

  // Flag storage with independent per-flag loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z_r <= 1'b0;
      flag_c_r <= 1'b0;
    end else begin
      if (z_en) begin
        flag_z_r <= z_in;
      end else begin
        flag_z_r <= flag_z_r;
      end
      if (c_en) begin
        flag_c_r <= c_in;
      end else begin
        flag_c_r <= flag_c_r;
      end
    end
  end

  assign flag_z = flag_z_r;
  assign flag_c = flag_c_r;

endmodule

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
//   Registers ALU results on a valid/ready handshake and sequences the
//   register-file writes. A write appears on the cycle after its accept.
//   A MUL produces two writes: the LO half goes to Rd, then the HI half goes
//   to Rd+1, which wraps around the register file. The stage also keeps the
//   Z/C flag register up to date.
//   Ports: Clock, Reset (synchronous, active-high), bus (slave side of
//          alu_writeback_stage_if), RfWe/RfAddr/RfData (registered write
//          port), FlagZ/FlagC (architectural flags), Busy (a write is on the
//          outputs).
//   Build option ALU_WB_MUL_EN: when it is defined, MUL uses the two-write
//   sequence and the S_HI state. When it is undefined, ALUOp 111 is handled
//   as an ordinary single write of Result, MulResult is ignored, and InReady
//   is high except during Reset.
module alu_writeback_stage
  import cpu16_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW,
  parameter int OP_W   = CPU_OP_W
) (
  input  logic                 Clock,
  input  logic                 Reset,
  alu_writeback_stage_if.slave bus,
  output logic                 RfWe,
  output logic [REG_AW-1:0]    RfAddr,
  output logic [DATA_W-1:0]    RfData,
  output logic                 FlagZ,
  output logic                 FlagC,
  output logic                 Busy
);

  wb_state_e           state_r;
  wb_state_e           state_nx;
  logic                rf_we_r;
  logic                rf_we_nx;
  logic [REG_AW-1:0]   rf_addr_r;
  logic [REG_AW-1:0]   rf_addr_nx;
  logic [DATA_W-1:0]   rf_data_r;
  logic [DATA_W-1:0]   rf_data_nx;
  logic                busy_r;
  logic                ready_s;
  logic                accept_s;
  logic                load_s;
  logic                z_in_s;
  logic                c_en_s;

`ifdef ALU_WB_MUL_EN
  logic                is_mul_r;
  logic                is_mul_nx;
  logic [DATA_W-1:0]   hi_data_r;
  logic [DATA_W-1:0]   hi_data_nx;
  logic                mul_op_s;

  assign mul_op_s = (bus.ALUOp == OP_MUL);

  // Ready is low during the LO cycle of a MUL, because the HI write still owns the next cycle.
  always_comb begin
    if (Reset) begin
      ready_s = 1'b0;
    end else if ((state_r == S_WR) && is_mul_r) begin
      ready_s = 1'b0;
    end else begin
      ready_s = 1'b1;
    end
  end

  // The zero flag of a MUL reflects the whole product.
  always_comb begin
    if (mul_op_s) begin
      z_in_s = (bus.MulResult == {(2*DATA_W){1'b0}});
    end else begin
      z_in_s = bus.Zero;
    end
  end
`else
  logic unused_mul_s;
  assign unused_mul_s = ^bus.MulResult;

  // Without MUL sequencing the stage can always take a new op, except during Reset.
  always_comb begin
    if (Reset) begin
      ready_s = 1'b0;
    end else begin
      ready_s = 1'b1;
    end
  end

  assign z_in_s = bus.Zero;
`endif

  // Reset takes priority: ready_s is low during Reset, so nothing is accepted then.
  assign accept_s    = bus.InValid & ready_s;
  assign load_s      = accept_s & bus.RegWrite;
  assign c_en_s      = accept_s & op_sets_carry(bus.ALUOp);
  assign bus.InReady = ready_s;

  // Next-state logic and next values for the registered write port.
  always_comb begin
    state_nx   = state_r;
    rf_we_nx   = 1'b0;
    rf_addr_nx = rf_addr_r;
    rf_data_nx = rf_data_r;
`ifdef ALU_WB_MUL_EN
    is_mul_nx  = is_mul_r;
    hi_data_nx = hi_data_r;
`endif

    case (state_r)
      S_IDLE: begin
        if (load_s) begin
          state_nx = S_WR;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_WR: begin
`ifdef ALU_WB_MUL_EN
        if (is_mul_r) begin
          state_nx = S_HI;
        end else if (load_s) begin
          state_nx = S_WR;
        end else begin
          state_nx = S_IDLE;
        end
`else
        if (load_s) begin
          state_nx = S_WR;
        end else begin
          state_nx = S_IDLE;
        end
`endif
      end
`ifdef ALU_WB_MUL_EN
      S_HI: begin
        if (load_s) begin
          state_nx = S_WR;
        end else begin
          state_nx = S_IDLE;
        end
      end
`endif
      default: begin
        state_nx = S_IDLE;
      end
    endcase

`ifdef ALU_WB_MUL_EN
    if ((state_r == S_WR) && is_mul_r) begin
      // The HI half goes to the register after Rd. The address wraps at the width of the register file.
      rf_we_nx   = 1'b1;
      rf_addr_nx = rf_addr_r + {{(REG_AW-1){1'b0}}, 1'b1};
      rf_data_nx = hi_data_r;
      is_mul_nx  = 1'b0;
    end else if (load_s) begin
      rf_we_nx   = 1'b1;
      rf_addr_nx = bus.Rd;
      is_mul_nx  = mul_op_s;
      if (mul_op_s) begin
        rf_data_nx = bus.MulResult[DATA_W-1:0];
        hi_data_nx = bus.MulResult[2*DATA_W-1:DATA_W];
      end else begin
        rf_data_nx = bus.Result;
        hi_data_nx = hi_data_r;
      end
    end else begin
      rf_we_nx = 1'b0;
    end
`else
    if (load_s) begin
      rf_we_nx   = 1'b1;
      rf_addr_nx = bus.Rd;
      rf_data_nx = bus.Result;
    end else begin
      rf_we_nx = 1'b0;
    end
`endif
  end

  // State register and registered write-port outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r   <= S_IDLE;
      rf_we_r   <= 1'b0;
      rf_addr_r <= {REG_AW{1'b0}};
      rf_data_r <= {DATA_W{1'b0}};
      busy_r    <= 1'b0;
`ifdef ALU_WB_MUL_EN
      is_mul_r  <= 1'b0;
      hi_data_r <= {DATA_W{1'b0}};
`endif
    end else begin
      state_r   <= state_nx;
      rf_we_r   <= rf_we_nx;
      rf_addr_r <= rf_addr_nx;
      rf_data_r <= rf_data_nx;
      busy_r    <= (state_nx != S_IDLE);
`ifdef ALU_WB_MUL_EN
      is_mul_r  <= is_mul_nx;
      hi_data_r <= hi_data_nx;
`endif
    end
  end

  alu_flag_reg u_flags (
    .clk    (Clock),
    .rst    (Reset),
    .z_en   (accept_s),
    .z_in   (z_in_s),
    .c_en   (c_en_s),
    .c_in   (bus.CarryOut),
    .flag_z (FlagZ),
    .flag_c (FlagC)
  );

  assign RfWe   = rf_we_r;
  assign RfAddr = rf_addr_r;
  assign RfData = rf_data_r;
  assign Busy   = busy_r;

endmodule
